gerador_sequencia: RTL and testbench

Serial pattern transmitter: the source end of the serial `x` line that feeds the consecutive-ones sequence detector. It loads a parallel pattern word on a start request and shifts it out MSB-first, one bit per clock, under a start/busy/done handshake. It also produces `y_esperado`, the value a conforming detector's `y` must show each cycle, so benches can self-check the detector against this generator.

---
 rtl/gerador_sequencia.sv | 103 ++++++++++
 tb/tb_gerador_sequencia.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gerador_sequencia.sv
// gerador_sequencia: serial pattern transmitter for the consecutive-ones
// detector. Loads a parallel word on start, shifts it out MSB-first with a
// start/busy/done handshake, and tracks the detector's expected output.
module gerador_sequencia #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           padrao,
    input  logic [$clog2(WIDTH):0]     tamanho,
    output logic                       x,
    output logic                       valido,
    output logic                       ocupado,
    output logic                       fim,
    output logic                       y_esperado
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [1:0]        run_q,   run_d;

    // Outputs are pure decodes of the registered state: no input reaches an
    // output combinationally, and an asynchronous reset clears them at once.
    assign valido     = (state_q == SHIFT);
    assign x          = valido && shreg_q[WIDTH-1];
    assign ocupado    = (state_q != IDLE);
    assign fim        = (state_q == DONE);
    assign y_esperado = (run_q == 2'd3);

    // Next-state logic for the transmit FSM, shift register and bit counter.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // A zero length is a no-op request; oversize lengths clamp.
                if (start && (tamanho != '0)) begin
                    shreg_d = padrao;
                    cnt_d   = (tamanho > WIDTH_C) ? WIDTH_C : tamanho;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating count of consecutive transmitted ones; any other cycle
    // (a 0 bit, DONE, IDLE) drives x low and so restarts the run.
    always_comb begin
        run_d = 2'd0;
        if (valido && x) begin
            run_d = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
        end
    end

    // State registers with asynchronous active-low reset; an interrupted
    // pattern is discarded, not resumed.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            // NOTE: the shift register is reset too (not just the FSM) so no
            // stale pattern bits survive a reset.
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            run_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_gerador_sequencia.sv
// Self-checking bench for gerador_sequencia: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// timeline-based model of the transmitter.
module tb_gerador_sequencia;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] padrao;
    logic [CW-1:0]    tamanho;
    logic             x, valido, ocupado, fim, y_esperado;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    gerador_sequencia #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .padrao     (padrao),
        .tamanho    (tamanho),
        .x          (x),
        .valido     (valido),
        .ocupado    (ocupado),
        .fim        (fim),
        .y_esperado (y_esperado)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transmission is a time window: bits on cycles t0..t0+n-1, fim on
    // cycle t0+n. The ones run is an unbounded count of consecutive 1 bits.
    int               cyc      = 0;
    bit               m_active = 1'b0;
    int               m_t0     = 0;
    int               m_n      = 0;
    logic [WIDTH-1:0] m_pat    = '0;
    int               m_run    = 0;
    logic [4:0]       m_o;

    // Expected {x, valido, ocupado, fim, y_esperado} for the current cycle.
    function automatic logic [4:0] model_out();
        logic xb, vb, ob, fb, yb;
        xb = 1'b0; vb = 1'b0; ob = 1'b0; fb = 1'b0;
        yb = (m_run >= 3);
        if (m_active && cyc >= m_t0 && cyc < m_t0 + m_n) begin
            vb = 1'b1;
            ob = 1'b1;
            xb = m_pat[WIDTH-1-(cyc-m_t0)];
        end else if (m_active && cyc == m_t0 + m_n) begin
            ob = 1'b1;
            fb = 1'b1;
        end
        return {xb, vb, ob, fb, yb};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_run    = 0;
            end else begin
                m_o = model_out();
                if (m_o[4] && m_o[3]) m_run++;
                else                  m_run = 0;
                if (!m_o[2] && start && tamanho != 0) begin
                    m_active = 1'b1;
                    m_t0     = cyc + 1;
                    m_n      = (int'(tamanho) > WIDTH) ? WIDTH : int'(tamanho);
                    m_pat    = padrao;
                end
                cyc++;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) check($sformatf("model_cyc%0d", cyc),
                              {x, valido, ocupado, fim, y_esperado}, model_out());
        end
    end

    // ---------------- directed helpers ----------------
    // Called at posedge+1: presents a request, lets it be sampled, then
    // scrambles padrao/tamanho while the block is busy.
    task automatic go_start(input logic [WIDTH-1:0] p, input logic [CW-1:0] t);
        start   = 1'b1;
        padrao  = p;
        tamanho = t;
        @(posedge clk);
        #1;
        start   = 1'b0;
        padrao  = ~p;
        tamanho = CW'($urandom_range(0, 15));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ex_x, ex_y, ex_f, ex_o;

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        padrao  = '0;
        tamanho = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_state", {x, valido, ocupado, fim, y_esperado}, 5'b0);
        next_cycle();

        // Full pattern 1110_0111, cycles 1..10 (bit c-1 = cycle c)
        ex_x = 16'b0000_0000_1110_0111;
        ex_y = 16'b0000_0001_0000_1000;
        ex_f = 16'b0000_0001_0000_0000;
        ex_o = 16'b0000_0001_1111_1111;
        go_start(8'b1110_0111, 4'd8);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("full_c%0d", c), {x, y_esperado, fim, ocupado},
                  {ex_x[c-1], ex_y[c-1], ex_f[c-1], ex_o[c-1]});
            next_cycle();
        end

        // Short pattern 8'hE0, length 3, cycles 1..5
        ex_x = 16'b0000_0000_0000_0111;
        ex_y = 16'b0000_0000_0000_1000;
        ex_f = 16'b0000_0000_0000_1000;
        ex_o = 16'b0000_0000_0000_1111;
        go_start(8'hE0, 4'd3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("short_c%0d", c), {x, y_esperado, fim, ocupado},
                  {ex_x[c-1], ex_y[c-1], ex_f[c-1], ex_o[c-1]});
            next_cycle();
        end

        // Zero length is ignored
        start = 1'b1; padrao = 8'hFF; tamanho = 4'd0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("zero_len_c%0d", c), {x, ocupado}, 2'b00);
            next_cycle();
        end
        start = 1'b0;

        // Clamped length 12 -> 8 bits of 8'hA5, fim in cycle 9
        ex_x = 16'b0000_0000_1010_0101;
        ex_f = 16'b0000_0001_0000_0000;
        ex_o = 16'b0000_0001_1111_1111;
        go_start(8'hA5, 4'd12);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("clamp_c%0d", c), {x, fim, ocupado},
                  {ex_x[c-1], ex_f[c-1], ex_o[c-1]});
            next_cycle();
        end

        // Start held high: 8'hC0, length 2 -> x = 1,1,0,0 repeating
        start = 1'b1; padrao = 8'hC0; tamanho = 4'd2;
        next_cycle();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("held_c%0d", c), {x, y_esperado, fim},
                  {((c - 1) % 4) < 2, 1'b0, ((c - 1) % 4) == 2});
            next_cycle();
        end
        start = 1'b0;
        repeat (6) next_cycle();

        // Reset during bit 4 of 8'hFF (y_esperado is high then)
        go_start(8'hFF, 4'd8);
        repeat (3) next_cycle();
        @(negedge clk);
        check("pre_reset_y", {x, valido, ocupado, fim, y_esperado}, 5'b11101);
        next_cycle();
        #1 rst_n = 1'b0;
        #1 check("async_reset", {x, valido, ocupado, fim, y_esperado}, 5'b0);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("post_reset_c%0d", c), {x, ocupado}, 2'b00);
            next_cycle();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 9) < 4);
            padrao  = WIDTH'($urandom);
            tamanho = CW'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            next_cycle();
        end

        start = 1'b0;
        repeat (12) next_cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
